// File: rtl/mp_add_seq_pkg.sv
// mp_add_seq_pkg
//   Shared constants and types for the multi-precision add/subtract sequencer.
//   - W_DEF / WORDS_DEF : default slice width and number of words per operand
//   - IDX_W_DEF         : width of the word index for the default configuration
//   - state_e           : sequencer state encoding (IDLE / RUN)
package mp_add_seq_pkg;

    localparam int W_DEF     = 8;
    localparam int WORDS_DEF = 4;
    localparam int IDX_W_DEF = $clog2(WORDS_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mp_add_seq_add_slice.sv
// add_slice
//   Purely combinational W-bit ripple-carry adder built from a full-adder chain.
//   Ports:
//     a, b : W-bit addends
//     ci   : carry in to bit 0
//     s    : W-bit sum
//     co   : carry out of bit W-1
module add_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[W];
    end

endmodule

// File: rtl/mp_add_seq.sv
// mp_add_seq
//   Multi-precision add/subtract sequencer. One shared W-bit ripple adder
//   processes a WORDS*W-bit operation one word per cycle, LSW first, with the
//   carry held in a register between words.
//   Ports:
//     clk, rst_n      : clock (rising edge), asynchronous active-low reset
//     start, sub, cin : request, operation select (1 = a-b), carry-in for add
//     op_a, op_b      : full-width operands, captured on an accepted start
//     busy            : operation in progress
//     done            : one-cycle pulse when result/cout/ovf are valid
//     result          : sum or difference, held until the next accepted start
//     cout            : final carry out (for sub, 1 = no borrow)
//     ovf             : two's-complement signed overflow of the full result
module mp_add_seq
    import mp_add_seq_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sub,
    input  logic [W*WORDS-1:0] op_a,
    input  logic [W*WORDS-1:0] op_b,
    input  logic               cin,
    output logic               busy,
    output logic               done,
    output logic [W*WORDS-1:0] result,
    output logic               cout,
    output logic               ovf
);

    localparam int N     = W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic               carry_q,  carry_d;
    logic [N-1:0]       a_q,      a_d;
    logic [N-1:0]       b_q,      b_d;
    logic [N-1:0]       result_q, result_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;
    logic               done_q,   done_d;
    logic               busy_q,   busy_d;

    logic [W-1:0]       a_word;
    logic [W-1:0]       b_word;
    logic [W-1:0]       s_word;
    logic               s_co;

    // b_q already holds the effective operand (inverted for subtract), so the
    // slice never needs to know which operation is in flight.
    assign a_word = a_q[int'(idx_q)*W +: W];
    assign b_word = b_q[int'(idx_q)*W +: W];

    add_slice #(.W(W)) u_slice (
        .a  (a_word),
        .b  (b_word),
        .ci (carry_q),
        .s  (s_word),
        .co (s_co)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    // Subtract as a + ~b + 1; the +1 rides in on the carry register.
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[int'(idx_q)*W +: W] = s_word;
                carry_d = s_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = s_co;
                    // Signed overflow: operands share a sign that the sum does not.
                    ovf_d   = (a_word[W-1] == b_word[W-1]) && (s_word[W-1] != a_word[W-1]);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// tb_mp_add_seq
//   Directed, table-driven bench for mp_add_seq (W=8, WORDS=4) with
//   hand-written sequences for busy-start, back-to-back and mid-op reset.
module tb_mp_add_seq;

    localparam int W     = 8;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         cout;
    logic         ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    mp_add_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request on the falling edge; returns #1 after the accepting edge.
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b, input logic c);
        @(negedge clk);
        sub   = s;
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts rising edges until done is seen (sampled #1 after the edge).
    task automatic wait_done(output int edges, output int busy_cnt, output bit ok);
        edges    = 0;
        busy_cnt = busy ? 1 : 0;
        ok       = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    initial begin
        int  edges;
        int  bcnt;
        bit  ok;
        int  n_done;
        logic [31:0] bb_a[3];
        logic [31:0] bb_b[3];
        logic        bb_s[3];
        logic        bb_c[3];
        logic [31:0] bb_r[3];
        logic        bb_co[3];

        vecs[0] = '{1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h00000010, 32'h00000003, 1'b1, 32'h0000000D, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};

        bb_s[0] = 1'b0; bb_a[0] = 32'h11111111; bb_b[0] = 32'h22222222; bb_c[0] = 1'b0;
        bb_r[0] = 32'h33333333; bb_co[0] = 1'b0;
        bb_s[1] = 1'b1; bb_a[1] = 32'h00000010; bb_b[1] = 32'h00000020; bb_c[1] = 1'b0;
        bb_r[1] = 32'hFFFFFFF0; bb_co[1] = 1'b0;
        bb_s[2] = 1'b0; bb_a[2] = 32'hFFFFFFFF; bb_b[2] = 32'h00000000; bb_c[2] = 1'b1;
        bb_r[2] = 32'h00000000; bb_co[2] = 1'b1;

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   64'(busy),   64'(0));
        check("rst_done",   64'(done),   64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_cout",   64'(cout),   64'(0));
        check("rst_ovf",    64'(ovf),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
            if (i > 0) begin
                check($sformatf("v%0d_hold_result", i), 64'(result), 64'(vecs[i-1].res));
                check($sformatf("v%0d_hold_cout", i),   64'(cout),   64'(vecs[i-1].cout));
                check($sformatf("v%0d_hold_ovf", i),    64'(ovf),    64'(vecs[i-1].ovf));
            end
            wait_done(edges, bcnt, ok);
            check($sformatf("v%0d_done_seen", i), 64'(ok),     64'(1));
            check($sformatf("v%0d_latency", i),   64'(edges),  64'(4));
            check($sformatf("v%0d_busy_cyc", i),  64'(bcnt),   64'(4));
            check($sformatf("v%0d_result", i),    64'(result), 64'(vecs[i].res));
            check($sformatf("v%0d_cout", i),      64'(cout),   64'(vecs[i].cout));
            check($sformatf("v%0d_ovf", i),       64'(ovf),    64'(vecs[i].ovf));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_1cyc", i), 64'(done),   64'(0));
            check($sformatf("v%0d_held", i),      64'(result), 64'(vecs[i].res));
        end

        // Start while busy is ignored
        start_op(1'b0, 32'h00000001, 32'h00000002, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start = 1'b1;
        op_a  = 32'hAAAAAAAA;
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) start = 1'b0;
            if (done) n_done++;
        end
        check("busy_start_ndone",  64'(n_done), 64'(1));
        check("busy_start_result", 64'(result), 64'(32'h00000003));
        check("busy_start_idle",   64'(busy),   64'(0));

        // Back-to-back with start held high
        @(negedge clk);
        sub   = bb_s[0];
        op_a  = bb_a[0];
        op_b  = bb_b[0];
        cin   = bb_c[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            wait_done(edges, bcnt, ok);
            check($sformatf("b2b%0d_done_seen", j), 64'(ok),     64'(1));
            check($sformatf("b2b%0d_spacing", j),   64'(edges),  64'((j == 0) ? 4 : 5));
            check($sformatf("b2b%0d_result", j),    64'(result), 64'(bb_r[j]));
            check($sformatf("b2b%0d_cout", j),      64'(cout),   64'(bb_co[j]));
            if (j < 2) begin
                sub  = bb_s[j+1];
                op_a = bb_a[j+1];
                op_b = bb_b[j+1];
                cin  = bb_c[j+1];
            end else begin
                start = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("b2b_end_idle", 64'(busy), 64'(0));

        // Reset mid-operation
        start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("midrst_busy_before", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   64'(busy),   64'(0));
        check("midrst_done",   64'(done),   64'(0));
        check("midrst_result", 64'(result), 64'(0));
        check("midrst_cout",   64'(cout),   64'(0));
        check("midrst_ovf",    64'(ovf),    64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("midrst_no_done", 64'(n_done), 64'(0));
        check("midrst_idle",    64'(busy),   64'(0));

        start_op(1'b0, 32'h12345678, 32'h11111111, 1'b0);
        wait_done(edges, bcnt, ok);
        check("postrst_done_seen", 64'(ok),     64'(1));
        check("postrst_latency",   64'(edges),  64'(4));
        check("postrst_result",    64'(result), 64'(32'h23456789));
        check("postrst_cout",      64'(cout),   64'(0));
        check("postrst_ovf",       64'(ovf),    64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
